// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO divider: default widths, FSM state
// encoding and the quotient written on divide-by-zero.
package hilo_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (purely combinational).
// Ports:
//   rem        : current partial remainder (always < divisor)
//   quo        : dividend bits still to shift in (MSB first) / quotient bits so far
//   divisor    : divisor magnitude
//   next_rem_c : partial remainder after this iteration
//   next_quo_c : quo shifted left with the new quotient bit in the LSB
module div_step
  import hilo_pkg::*;
#(
  parameter int unsigned W = WIDTH
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] next_rem_c,
  output logic [W-1:0] next_quo_c
);

  logic [W:0] rem_sh;
  logic [W:0] trial;

  // Shift {rem, quo} left by one; the trial subtract needs one extra bit.
  always_comb begin
    rem_sh = {rem, quo[W-1]};
    trial  = rem_sh - {1'b0, divisor};
    if (!trial[W]) begin
      next_rem_c = trial[W-1:0];
      next_quo_c = {quo[W-2:0], 1'b1};
    end else begin
      // Restore: rem_sh < divisor here, so it fits in W bits.
      next_rem_c = rem_sh[W-1:0];
      next_quo_c = {quo[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_div.sv
// Multi-cycle 32-bit divider owning the HI/LO register pair.
// div/divu write quotient to LO and remainder to HI after 33 busy cycles;
// mthi/mtlo load HI/LO from a while idle.
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   start      : begin a division (idle only); sign selects div (1) / divu (0)
//   a, b       : dividend / divisor; a is also the mthi/mtlo write data
//   mthi, mtlo : write a into HI / LO (idle only)
//   busy       : division in progress
//   done       : one-cycle pulse when HI/LO receive a division result
//   hi, lo     : HI (remainder) and LO (quotient) registers
module hilo_div
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = hilo_pkg::WIDTH,
  parameter int unsigned CNT_W = hilo_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   raw_a_q, raw_a_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic               div0_q, div0_d;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_quo;

  div_step #(.W(WIDTH)) u_step (
    .rem        (rem_q),
    .quo        (quo_q),
    .divisor    (dvsr_q),
    .next_rem_c (step_rem),
    .next_quo_c (step_quo)
  );

  // Operand magnitudes; unsigned negate keeps |0x80000000| = 0x80000000.
  always_comb begin
    mag_a = (sign && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    mag_b = (sign && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    raw_a_d = raw_a_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    div0_d  = div0_q;

    case (state_q)
      ST_IDLE: begin
        if (mthi) hi_d = a;
        if (mtlo) lo_d = a;
        if (start) begin
          rem_d   = '0;
          quo_d   = mag_a;
          dvsr_d  = mag_b;
          raw_a_d = a;
          neg_q_d = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r_d = sign & a[WIDTH-1];
          div0_d  = (b == '0);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (div0_q) begin
          lo_d = WIDTH'(DIV0_QUOTIENT);
          hi_d = raw_a_q;
        end else begin
          lo_d = neg_q_q ? (~quo_q + WIDTH'(1)) : quo_q;
          hi_d = neg_r_q ? (~rem_q + WIDTH'(1)) : rem_q;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      raw_a_q <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      raw_a_q <= raw_a_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      div0_q  <= div0_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_div.sv
// Directed and randomised self-checking bench for hilo_div and div_step.
module tb_hilo_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sign;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  logic [31:0] st_rem, st_quo, st_dvsr, st_nrem, st_nquo;

  int checks = 0;
  int errors = 0;

  hilo_div dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sign  (sign),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  div_step #(.W(32)) u_step (
    .rem        (st_rem),
    .quo        (st_quo),
    .divisor    (st_dvsr),
    .next_rem_c (st_nrem),
    .next_quo_c (st_nquo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive start for one edge (edge k); returns at edge k + 1ns.
  task automatic start_div(input logic [31:0] va, input logic [31:0] vb, input logic sg);
    a = va; b = vb; sign = sg; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait for done; 'elapsed' edges since edge k have already passed.
  task automatic wait_done(input string tag, input int elapsed,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int n;
    logic busy_ok;
    n = elapsed;
    busy_ok = busy;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    check({tag, "_latency"}, 32'(n), 32'd33);
    check({tag, "_busy_run"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_lo"}, lo, exp_lo);
    check({tag, "_hi"}, hi, exp_hi);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      5: return 32'($urandom_range(0, 100));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb, el, eh;
    logic        rs;

    rst = 1'b1; start = 1'b0; sign = 1'b0; a = '0; b = '0; mthi = 1'b0; mtlo = 1'b0;
    st_rem = '0; st_quo = '0; st_dvsr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    rst = 1'b0;

    // Single iteration unit checks.
    st_rem = 32'd3; st_quo = 32'h8000_0000; st_dvsr = 32'd7; #1;
    check("step_sub_rem", st_nrem, 32'd0);
    check("step_sub_quo", st_nquo, 32'd1);
    st_rem = 32'd2; st_quo = 32'h0000_0005; st_dvsr = 32'd7; #1;
    check("step_rst_rem", st_nrem, 32'd4);
    check("step_rst_quo", st_nquo, 32'h0000_000A);
    st_rem = 32'hFFFF_FFFE; st_quo = 32'h8000_0000; st_dvsr = 32'hFFFF_FFFF; #1;
    check("step_wide_rem", st_nrem, 32'hFFFF_FFFE);
    check("step_wide_quo", st_nquo, 32'd1);

    // mthi / mtlo in idle.
    @(posedge clk); #1;
    a = 32'hDEAD_BEEF; mthi = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0;
    check("mthi_hi", hi, 32'hDEAD_BEEF);
    a = 32'hCAFE_F00D; mtlo = 1'b1;
    @(posedge clk); #1;
    mtlo = 1'b0;
    check("mtlo_lo", lo, 32'hCAFE_F00D);
    check("mtlo_hi_kept", hi, 32'hDEAD_BEEF);

    // Basic divu, then signed cases back-to-back from the done cycle.
    start_div(32'd100, 32'd7, 1'b0);
    check("divu_busy0", {31'd0, busy}, 32'd1);
    wait_done("divu", 0, 32'd14, 32'd2);
    start_div(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done("div_neg_a", 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    start_div(32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_done("div_neg_b", 0, 32'hFFFF_FFFD, 32'd1);
    check("done_pulse", {31'd0, done}, 32'd1);
    start_div(32'h1234_5678, 32'd0, 1'b1);
    check("b2b_done_drop", {31'd0, done}, 32'd0);
    wait_done("div0", 0, 32'hFFFF_FFFF, 32'h1234_5678);
    start_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done("ovf", 0, 32'h8000_0000, 32'd0);

    // Inputs while busy are dropped; HI/LO hold during RUN.
    start_div(32'd100, 32'd7, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    a = 32'h5555_5555; b = 32'd3; mthi = 1'b1; mtlo = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0; start = 1'b0;
    check("busy_hi_hold", hi, 32'd0);
    check("busy_lo_hold", lo, 32'h8000_0000);
    wait_done("ignored", 6, 32'd14, 32'd2);

    // Asynchronous reset mid-run clears everything before any clock edge.
    start_div(32'd1234, 32'd5, 1'b0);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start_div(32'd1000, 32'd10, 1'b0);
    wait_done("post_rst", 0, 32'd100, 32'd0);

    // Randomised pairs against a language-level reference.
    for (int i = 0; i < 200; i++) begin
      ra = pick();
      rb = pick();
      rs = 1'($urandom_range(0, 1));
      if (rb == 32'd0) rb = 32'd1;
      if (rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      if (rs) begin
        el = 32'($signed(ra) / $signed(rb));
        eh = 32'($signed(ra) % $signed(rb));
      end else begin
        el = ra / rb;
        eh = ra % rb;
      end
      start_div(ra, rb, rs);
      wait_done($sformatf("rnd%0d", i), 0, el, eh);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
